// File: rtl/wakeup_scheduler.sv
// Purpose: shares one delay-wakeup shift-register timer among NUM_REQ requesters (round-robin, clamp, watchdog).
// Latency: gnt 1 cycle after req is sampled, tmr_load 1 cycle later, wake 1 cycle after tmr_valid (or watchdog expiry).
// Backpressure: one request is served at a time; req is sampled only in IDLE, so other requesters hold until granted.
module wakeup_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int DLAY_LEN   = 8,
   parameter int CNT_W      = 4,
   parameter int WDOG_SLACK = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*CNT_W-1:0]    req_dly,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          wake,
   output logic                        wake_err,
   output logic                        sat_err,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  cur_id,
   output logic                        tmr_load,
   output logic [DLAY_LEN-1:0]         tmr_wdy,
   input  logic                        tmr_valid
);

   localparam int ID_W   = $clog2(NUM_REQ);
   localparam int WD_LIM = DLAY_LEN + WDOG_SLACK;
   localparam int WD_W   = $clog2(WD_LIM + 1);
   localparam logic [CNT_W-1:0] DLY_MAX = CNT_W'(DLAY_LEN);

   // GRANT is the cycle gnt is visible; LOAD is the cycle tmr_load is visible.
   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_LOAD,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   last_gnt;
   logic [CNT_W-1:0]  dly_q;
   logic [WD_W-1:0]   wdog;

   logic              win_vld;
   logic [ID_W-1:0]   win_id;
   logic [CNT_W-1:0]  win_dly;

   // Round-robin pick: first set req bit searching upward from last_gnt+1.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!win_vld && req[(int'(last_gnt) + k) % NUM_REQ]) begin
            win_vld = 1'b1;
            win_id  = ID_W'((int'(last_gnt) + k) % NUM_REQ);
         end
      end
      win_dly = req_dly[int'(win_id)*CNT_W +: CNT_W];
   end

   // Control FSM; every output is a register written on the transition into the cycle it marks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         last_gnt <= ID_W'(NUM_REQ - 1);
         dly_q    <= '0;
         wdog     <= '0;
         gnt      <= '0;
         wake     <= '0;
         wake_err <= 1'b0;
         sat_err  <= 1'b0;
         busy     <= 1'b0;
         cur_id   <= '0;
         tmr_load <= 1'b0;
         tmr_wdy  <= '0;
      end else begin
         gnt      <= '0;
         wake     <= '0;
         wake_err <= 1'b0;
         sat_err  <= 1'b0;
         tmr_load <= 1'b0;
         tmr_wdy  <= '0;
         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  state  <= S_GRANT;
                  cur_id <= win_id;
                  gnt    <= NUM_REQ'(1) << win_id;
                  busy   <= 1'b1;
                  // Delays beyond the shift-register length are clamped and flagged.
                  if (win_dly > DLY_MAX) begin
                     dly_q   <= DLY_MAX;
                     sat_err <= 1'b1;
                  end else begin
                     dly_q   <= win_dly;
                  end
               end
            end
            S_GRANT: begin
               if (dly_q == '0) begin
                  // Zero delay never touches the timer.
                  state <= S_DONE;
                  wake  <= NUM_REQ'(1) << cur_id;
               end else begin
                  state    <= S_LOAD;
                  tmr_load <= 1'b1;
                  tmr_wdy  <= DLAY_LEN'(1) << (dly_q - 1'b1);
               end
            end
            S_LOAD: begin
               state <= S_WAIT;
               wdog  <= '0;
            end
            S_WAIT: begin
               // tmr_valid takes priority over a coincident watchdog expiry.
               if (tmr_valid) begin
                  state <= S_DONE;
                  wake  <= NUM_REQ'(1) << cur_id;
               end else if (wdog == WD_W'(WD_LIM - 1)) begin
                  state    <= S_DONE;
                  wake     <= NUM_REQ'(1) << cur_id;
                  wake_err <= 1'b1;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               last_gnt <= cur_id;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wakeup_scheduler.sv
// Self-checking bench for wakeup_scheduler with a behavioural delay timer and a gnt/load/wake scoreboard.
// Expectations are queued when a request is driven and compared by a negedge monitor as outputs appear.
// Each scenario task also checks cycle latencies inline.
module tb_wakeup_scheduler;

   localparam int NUM_REQ    = 4;
   localparam int DLAY_LEN   = 8;
   localparam int CNT_W      = 4;
   localparam int WDOG_SLACK = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_dly;
   logic [3:0]  gnt;
   logic [3:0]  wake;
   logic        wake_err;
   logic        sat_err;
   logic        busy;
   logic [1:0]  cur_id;
   logic        tmr_load;
   logic [7:0]  tmr_wdy;
   logic        tmr_valid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   wakeup_scheduler #(
      .NUM_REQ(NUM_REQ), .DLAY_LEN(DLAY_LEN), .CNT_W(CNT_W), .WDOG_SLACK(WDOG_SLACK)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_dly(req_dly),
      .gnt(gnt), .wake(wake), .wake_err(wake_err), .sat_err(sat_err),
      .busy(busy), .cur_id(cur_id), .tmr_load(tmr_load), .tmr_wdy(tmr_wdy),
      .tmr_valid(tmr_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural timer: valid is seen d cycles after the load edge; can be overridden manually.
   int   mcnt = 0;
   logic model_on;
   logic man_valid;
   always @(posedge clk) begin
      if (tmr_load) begin
         mcnt <= 0;
         for (int i = 0; i < DLAY_LEN; i++) if (tmr_wdy[i]) mcnt <= i + 1;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
      end
   end
   assign tmr_valid = model_on ? (mcnt == 1) : man_valid;

   // Scoreboard queues: {sat_err,gnt}, tmr_wdy, {wake_err,wake}.
   logic [4:0] exp_gnt_q[$];
   logic [7:0] exp_wdy_q[$];
   logic [4:0] exp_wake_q[$];

   int t_gnt = 0, t_load = 0, t_wake = 0;
   int n_gnt = 0, n_load = 0, n_wake = 0;
   int outstanding = 0;
   int t_req = 0;

   function automatic int idx_of(input logic [3:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Monitor: pops expectations as gnt, tmr_load and wake appear.
   always @(negedge clk) begin
      logic [4:0] e;
      logic [7:0] w;
      if (!rst) begin
         if (gnt != 4'b0) begin
            n_gnt++;
            t_gnt = cyc;
            checks++;
            if (outstanding != 0) begin
               errors++;
               $display("FAIL gnt_overlap: gnt=%b issued before previous wake", gnt);
            end
            outstanding = 1;
            checks++;
            if (exp_gnt_q.size() == 0) begin
               errors++;
               $display("FAIL gnt_unexpected: gnt=%b sat_err=%b, none expected", gnt, sat_err);
            end else begin
               e = exp_gnt_q.pop_front();
               if ({sat_err, gnt} !== e) begin
                  errors++;
                  $display("FAIL gnt_value: got sat_err,gnt=%b want %b", {sat_err, gnt}, e);
               end
               checks++;
               if (busy !== 1'b1 || cur_id !== 2'(idx_of(e[3:0]))) begin
                  errors++;
                  $display("FAIL gnt_status: busy=%b cur_id=%0d want busy=1 cur_id=%0d",
                           busy, cur_id, idx_of(e[3:0]));
               end
            end
         end
         if (tmr_load) begin
            n_load++;
            t_load = cyc;
            checks++;
            if (exp_wdy_q.size() == 0) begin
               errors++;
               $display("FAIL load_unexpected: tmr_wdy=%h, no load expected", tmr_wdy);
            end else begin
               w = exp_wdy_q.pop_front();
               if (tmr_wdy !== w) begin
                  errors++;
                  $display("FAIL load_wdy: got %h want %h", tmr_wdy, w);
               end
            end
         end else begin
            if (tmr_wdy !== 8'h00) begin
               checks++;
               errors++;
               $display("FAIL wdy_idle: tmr_wdy=%h without tmr_load, want 00", tmr_wdy);
            end
         end
         if (wake != 4'b0) begin
            n_wake++;
            t_wake = cyc;
            outstanding = 0;
            checks++;
            if (exp_wake_q.size() == 0) begin
               errors++;
               $display("FAIL wake_unexpected: wake=%b wake_err=%b, none expected", wake, wake_err);
            end else begin
               e = exp_wake_q.pop_front();
               if ({wake_err, wake} !== e) begin
                  errors++;
                  $display("FAIL wake_value: got wake_err,wake=%b want %b", {wake_err, wake}, e);
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_sb();
      exp_gnt_q.delete();
      exp_wdy_q.delete();
      exp_wake_q.delete();
      outstanding = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_sb();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_wakes(input int target, input int limit, input string name);
      int k;
      k = 0;
      while (n_wake < target && k < limit) begin
         tick();
         k++;
      end
      checks++;
      if (n_wake < target) begin
         errors++;
         $display("FAIL %s_timeout: wakes=%0d want %0d within %0d cycles", name, n_wake, target, limit);
      end
   endtask

   // Drive one request, queue its expectations, hold req until gnt and then drop it.
   task automatic request(input int id, input int d, input logic [7:0] wdy,
                          input logic sat, input logic err);
      int k;
      int bg;
      req_dly[id*4 +: 4] = 4'(d);
      exp_gnt_q.push_back({sat, 4'(1) << id});
      if (d != 0) exp_wdy_q.push_back(wdy);
      exp_wake_q.push_back({err, 4'(1) << id});
      bg    = n_gnt;
      t_req = cyc;
      req[id] = 1'b1;
      k = 0;
      while (n_gnt == bg && k < 20) begin
         tick();
         k++;
      end
      checks++;
      if (n_gnt == bg) begin
         errors++;
         $display("FAIL gnt_timeout: no gnt for requester %0d", id);
      end
      req[id] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({gnt, wake, wake_err, sat_err, busy, cur_id, tmr_load, tmr_wdy} !== 23'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0",
                  {gnt, wake, wake_err, sat_err, busy, cur_id, tmr_load, tmr_wdy});
      end
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || n_gnt != 0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b grants=%0d want 0 and 0", busy, n_gnt);
      end
   endtask

   task automatic test_single();
      int bw;
      bw = n_wake;
      request(1, 3, 8'h04, 1'b0, 1'b0);
      checks++;
      if (t_gnt - t_req != 1) begin
         errors++;
         $display("FAIL single_gnt_lat: got %0d want 1", t_gnt - t_req);
      end
      wait_wakes(bw + 1, 30, "single");
      checks++;
      if (t_load - t_req != 2) begin
         errors++;
         $display("FAIL single_load_lat: got %0d want 2", t_load - t_req);
      end
      checks++;
      if (t_wake - t_load != 4) begin
         errors++;
         $display("FAIL single_wake_lat: load-to-wake got %0d want 4", t_wake - t_load);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_round_robin();
      int bg, bw, k;
      logic [3:0] order [5];
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;
      do_reset();
      req_dly = 16'h1111;
      for (int r = 0; r < 5; r++) begin
         exp_gnt_q.push_back({1'b0, order[r]});
         exp_wdy_q.push_back(8'h01);
         exp_wake_q.push_back({1'b0, order[r]});
      end
      bg = n_gnt;
      bw = n_wake;
      req = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         k = 0;
         while (n_gnt < bg + r + 1 && k < 30) begin
            tick();
            k++;
         end
         if (r > 0) begin
            checks++;
            if (t_gnt - t_wake != 2) begin
               errors++;
               $display("FAIL rr_gap: wake-to-next-gnt got %0d want 2", t_gnt - t_wake);
            end
         end
         wait_wakes(bw + r + 1, 30, "rr");
      end
      req = 4'b0000;
      tick();
      tick();
      tick();
   endtask

   task automatic test_boundaries();
      int bl, bw;
      bl = n_load;
      bw = n_wake;
      request(2, 0, 8'h00, 1'b0, 1'b0);
      wait_wakes(bw + 1, 20, "d0");
      checks++;
      if (t_wake - t_gnt != 1) begin
         errors++;
         $display("FAIL d0_wake_lat: gnt-to-wake got %0d want 1", t_wake - t_gnt);
      end
      checks++;
      if (n_load != bl) begin
         errors++;
         $display("FAIL d0_no_load: loads=%0d want %0d", n_load, bl);
      end
      tick();
      request(3, 8, 8'h80, 1'b0, 1'b0);
      wait_wakes(bw + 2, 30, "d8");
      checks++;
      if (t_wake - t_load != 9) begin
         errors++;
         $display("FAIL d8_wake_lat: load-to-wake got %0d want 9", t_wake - t_load);
      end
      tick();
      request(0, 12, 8'h80, 1'b1, 1'b0);
      wait_wakes(bw + 3, 30, "d12");
      tick();
   endtask

   task automatic test_watchdog();
      int bw, bl, k;
      model_on  = 1'b0;
      man_valid = 1'b0;
      bw = n_wake;
      request(3, 5, 8'h10, 1'b0, 1'b1);
      wait_wakes(bw + 1, 40, "wdog");
      // The edge ending the load cycle enters WAIT; timeout is 10 edges after it.
      checks++;
      if (t_wake - t_load != 11) begin
         errors++;
         $display("FAIL wdog_lat: load-to-wake got %0d want 11", t_wake - t_load);
      end
      tick();
      bl = n_load;
      request(1, 5, 8'h10, 1'b0, 1'b0);
      k = 0;
      while (n_load == bl && k < 10) begin
         tick();
         k++;
      end
      k = 0;
      while (cyc < t_load + 10 && k < 20) begin
         tick();
         k++;
      end
      man_valid = 1'b1;
      tick();
      man_valid = 1'b0;
      wait_wakes(bw + 2, 20, "wdog_tie");
      checks++;
      if (t_wake - t_load != 11) begin
         errors++;
         $display("FAIL wdog_tie_lat: load-to-wake got %0d want 11", t_wake - t_load);
      end
      model_on = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      int bw, bl, bg, k;
      bl = n_load;
      request(0, 8, 8'h80, 1'b0, 1'b0);
      k = 0;
      while (n_load == bl && k < 10) begin
         tick();
         k++;
      end
      tick();
      tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy_pre: got %b want 1", busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({gnt, wake, wake_err, sat_err, busy, cur_id, tmr_load, tmr_wdy} !== 23'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h want 0",
                  {gnt, wake, wake_err, sat_err, busy, cur_id, tmr_load, tmr_wdy});
      end
      clear_sb();
      bw = n_wake;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (n_wake != bw || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_wake: wakes=%0d busy=%b want %0d and 0", n_wake, busy, bw);
      end
      // Spurious valid while idle.
      model_on  = 1'b0;
      bg = n_gnt;
      man_valid = 1'b1;
      tick();
      man_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || n_wake != bw || n_gnt != bg) begin
         errors++;
         $display("FAIL spurious_valid: busy=%b wakes=%0d gnts=%0d want 0,%0d,%0d",
                  busy, n_wake, n_gnt, bw, bg);
      end
      model_on = 1'b1;
      request(2, 1, 8'h01, 1'b0, 1'b0);
      checks++;
      if (t_gnt - t_req != 1) begin
         errors++;
         $display("FAIL post_spurious_gnt_lat: got %0d want 1", t_gnt - t_req);
      end
      wait_wakes(bw + 1, 20, "post_spurious");
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      req       = 4'b0000;
      req_dly   = 16'h0000;
      model_on  = 1'b1;
      man_valid = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_boundaries();
      test_watchdog();
      test_reset_mid();
      checks++;
      if (exp_gnt_q.size() != 0 || exp_wdy_q.size() != 0 || exp_wake_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: left gnt=%0d wdy=%0d wake=%0d want 0",
                  exp_gnt_q.size(), exp_wdy_q.size(), exp_wake_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
